multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the MIPS core: replaces the single-cycle opcode decoder with a Moore FSM

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the shared MIPS datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCWriteNe;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic       mem_err;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCWriteNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, mem_err, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCWriteNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, mem_err, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS core: FETCH..WB per instruction,
// with a bounded wait on the variable-latency unified memory.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_if.master       bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ANDIEX = 4'd12,
        S_IMMWB  = 4'd13
    } state_e;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              timeout_s;
    logic              abort_s;

    // State and memory-wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, wait counter and decoded control outputs
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCWriteNe   = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.illegal_op  = 1'b0;
        bus.state       = 4'd0;
        state_d         = state_q;
        cnt_d           = cnt_q;
        abort_s         = 1'b0;
        timeout_s       = (cnt_q == CNT_LAST) && !bus.mem_ready;

        if (reset) begin
            // Everything held quiet so an abandoned instruction cannot strobe late
            state_d = S_FETCH;
            cnt_d   = '0;
        end else begin
            bus.state = state_q;
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        state_d     = S_DECODE;
                    end else if (timeout_s) begin
                        abort_s = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    case (bus.opcode)
                        6'b000000: state_d = S_EXEC;
                        6'b100011,
                        6'b101011: state_d = S_MEMADR;
                        6'b000100: state_d = S_BEQ;
                        6'b000101: state_d = S_BNE;
                        6'b000010: state_d = S_JUMP;
                        6'b001000: state_d = S_ADDIEX;
                        6'b001100: state_d = S_ANDIEX;
                        default: begin
                            bus.illegal_op = 1'b1;
                            state_d        = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    if (bus.opcode == 6'b100011) begin
                        state_d = S_MEMRD;
                    end else begin
                        state_d = S_MEMWR;
                    end
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = S_MEMWB;
                    end else if (timeout_s) begin
                        abort_s = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_MEMRD;
                    end
                end
                S_MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                    state_d      = S_FETCH;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = S_FETCH;
                    end else if (timeout_s) begin
                        abort_s = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_MEMWR;
                    end
                end
                S_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                    state_d     = S_ALUWB;
                end
                S_ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                    state_d      = S_FETCH;
                end
                S_BEQ: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCSource    = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    state_d         = S_FETCH;
                end
                S_BNE: begin
                    bus.ALUSrcA   = 1'b1;
                    bus.ALUOp     = 2'b01;
                    bus.PCSource  = 2'b01;
                    bus.PCWriteNe = 1'b1;
                    state_d       = S_FETCH;
                end
                S_JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                    state_d      = S_FETCH;
                end
                S_ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = 2'b00;
                    state_d     = S_IMMWB;
                end
                S_ANDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = 2'b11;
                    state_d     = S_IMMWB;
                end
                S_IMMWB: begin
                    bus.RegWrite = 1'b1;
                    state_d      = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase

            // Every state change (and every abort) restarts the wait window; it saturates
            if ((state_d != state_q) || abort_s) begin
                cnt_d = '0;
            end else if (!bus.mem_ready && (cnt_q != CNT_LAST)) begin
                cnt_d = cnt_q + TO_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
        bus.mem_err = abort_s;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-accurate table/scoreboard bench for the multi-cycle MIPS sequencer.
module tb_multicycle_control;

    logic clk;
    logic reset;
    multicycle_control_if bus();

    multicycle_control #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [18:0] cw;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [18:0] cw;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   pass_cnt;
    int   total_cnt;

    logic [18:0] act_cw;
    assign act_cw = {bus.PCWrite, bus.PCWriteCond, bus.PCWriteNe, bus.IorD, bus.MemRead,
                     bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                     bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op,
                     bus.mem_err};

    function automatic logic [18:0] cw(input logic pcw, input logic pcc, input logic pcn,
                                       input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic m2r, input logic rd,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] aop, input logic [1:0] ps,
                                       input logic ill, input logic err);
        return {pcw, pcc, pcn, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, ill, err};
    endfunction

    logic [18:0] C_ZERO, C_FETCH_RDY, C_FETCH_WAIT, C_FETCH_ERR, C_DECODE, C_DECODE_ILL;
    logic [18:0] C_MEMADR, C_MEMRD, C_MEMRD_ERR, C_MEMWB, C_MEMWR, C_EXEC, C_ALUWB;
    logic [18:0] C_BEQ, C_BNE, C_JUMP, C_ADDIEX, C_ANDIEX, C_IMMWB;

    task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [18:0] w);
        vec_t v;
        v.rst = rst;
        v.op  = op;
        v.mr  = mr;
        v.st  = st;
        v.cw  = w;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, then check mid-cycle
    task automatic step(input string name, input logic rst, input logic [5:0] op,
                        input logic mr, input logic [3:0] st, input logic [18:0] w);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset         = rst;
        bus.opcode    = op;
        bus.mem_ready = mr;
        e.st = st;
        e.cw = w;
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        total_cnt++;
        if (bus.state === g.st && act_cw === g.cw) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     name, bus.state, act_cw, g.st, g.cw);
        end
    endtask

    initial begin
        clk           = 1'b0;
        reset         = 1'b1;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;
        pass_cnt      = 0;
        total_cnt     = 0;

        C_ZERO       = '0;
        C_FETCH_RDY  = cw(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
        C_FETCH_WAIT = cw(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
        C_FETCH_ERR  = cw(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b1);
        C_DECODE     = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0);
        C_DECODE_ILL = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,1'b0);
        C_MEMADR     = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
        C_MEMRD      = cw(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
        C_MEMRD_ERR  = cw(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
        C_MEMWB      = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
        C_MEMWR      = cw(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
        C_EXEC       = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0);
        C_ALUWB      = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
        C_BEQ        = cw(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0);
        C_BNE        = cw(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0);
        C_JUMP       = cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0);
        C_ADDIEX     = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
        C_ANDIEX     = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b11,2'b00,1'b0,1'b0);
        C_IMMWB      = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);

        // reset
        add(1'b1, 6'b000000, 1'b1, 4'd0,  C_ZERO);
        add(1'b1, 6'b001000, 1'b1, 4'd0,  C_ZERO);
        // addi
        add(1'b0, 6'b001000, 1'b1, 4'd0,  C_FETCH_RDY);
        add(1'b0, 6'b001000, 1'b1, 4'd1,  C_DECODE);
        add(1'b0, 6'b001000, 1'b1, 4'd11, C_ADDIEX);
        add(1'b0, 6'b001000, 1'b1, 4'd13, C_IMMWB);
        // lw with three wait cycles in MEMRD
        add(1'b0, 6'b100011, 1'b1, 4'd0,  C_FETCH_RDY);
        add(1'b0, 6'b100011, 1'b1, 4'd1,  C_DECODE);
        add(1'b0, 6'b100011, 1'b1, 4'd2,  C_MEMADR);
        add(1'b0, 6'b100011, 1'b0, 4'd3,  C_MEMRD);
        add(1'b0, 6'b100011, 1'b0, 4'd3,  C_MEMRD);
        add(1'b0, 6'b100011, 1'b0, 4'd3,  C_MEMRD);
        add(1'b0, 6'b100011, 1'b1, 4'd3,  C_MEMRD);
        add(1'b0, 6'b100011, 1'b1, 4'd4,  C_MEMWB);
        // beq then bne
        add(1'b0, 6'b000100, 1'b1, 4'd0,  C_FETCH_RDY);
        add(1'b0, 6'b000100, 1'b1, 4'd1,  C_DECODE);
        add(1'b0, 6'b000100, 1'b1, 4'd8,  C_BEQ);
        add(1'b0, 6'b000101, 1'b1, 4'd0,  C_FETCH_RDY);
        add(1'b0, 6'b000101, 1'b1, 4'd1,  C_DECODE);
        add(1'b0, 6'b000101, 1'b1, 4'd9,  C_BNE);
        // j
        add(1'b0, 6'b000010, 1'b1, 4'd0,  C_FETCH_RDY);
        add(1'b0, 6'b000010, 1'b1, 4'd1,  C_DECODE);
        add(1'b0, 6'b000010, 1'b1, 4'd10, C_JUMP);
        // R-type with opcode changing after DECODE (must be ignored)
        add(1'b0, 6'b000000, 1'b1, 4'd0,  C_FETCH_RDY);
        add(1'b0, 6'b000000, 1'b1, 4'd1,  C_DECODE);
        add(1'b0, 6'b111111, 1'b1, 4'd6,  C_EXEC);
        add(1'b0, 6'b100011, 1'b1, 4'd7,  C_ALUWB);
        // andi
        add(1'b0, 6'b001100, 1'b1, 4'd0,  C_FETCH_RDY);
        add(1'b0, 6'b001100, 1'b1, 4'd1,  C_DECODE);
        add(1'b0, 6'b001100, 1'b1, 4'd12, C_ANDIEX);
        add(1'b0, 6'b001100, 1'b1, 4'd13, C_IMMWB);
        // illegal opcode
        add(1'b0, 6'b111111, 1'b1, 4'd0,  C_FETCH_RDY);
        add(1'b0, 6'b111111, 1'b1, 4'd1,  C_DECODE_ILL);
        add(1'b0, 6'b111111, 1'b0, 4'd0,  C_FETCH_WAIT);
        add(1'b0, 6'b111111, 1'b1, 4'd0,  C_FETCH_RDY);
        // sw, reset arrives while waiting in MEMWR
        add(1'b0, 6'b101011, 1'b1, 4'd1,  C_DECODE);
        add(1'b0, 6'b101011, 1'b1, 4'd2,  C_MEMADR);
        add(1'b0, 6'b101011, 1'b0, 4'd5,  C_MEMWR);
        add(1'b1, 6'b101011, 1'b1, 4'd0,  C_ZERO);
        add(1'b0, 6'b101011, 1'b0, 4'd0,  C_FETCH_WAIT);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].op, tbl[i].mr, tbl[i].st, tbl[i].cw);
        end

        // Fetch timeout: fresh window after reset, abort on the 16th idle cycle
        step("fetch_prearm", 1'b1, 6'b000000, 1'b0, 4'd0, C_ZERO);
        for (int i = 0; i < 15; i++) begin
            step($sformatf("fetch_wait%0d", i), 1'b0, 6'b000000, 1'b0, 4'd0, C_FETCH_WAIT);
        end
        step("fetch_timeout", 1'b0, 6'b000000, 1'b0, 4'd0, C_FETCH_ERR);

        // Window restarts after abort; mem_ready on the last allowed cycle wins
        for (int i = 0; i < 15; i++) begin
            step($sformatf("fetch_rewait%0d", i), 1'b0, 6'b100011, 1'b0, 4'd0, C_FETCH_WAIT);
        end
        step("fetch_ready_wins", 1'b0, 6'b100011, 1'b1, 4'd0, C_FETCH_RDY);
        step("lw_decode", 1'b0, 6'b100011, 1'b1, 4'd1, C_DECODE);
        step("lw_memadr", 1'b0, 6'b100011, 1'b1, 4'd2, C_MEMADR);

        // Load times out in MEMRD: abort straight to FETCH with no register write
        for (int i = 0; i < 15; i++) begin
            step($sformatf("memrd_wait%0d", i), 1'b0, 6'b100011, 1'b0, 4'd3, C_MEMRD);
        end
        step("memrd_timeout", 1'b0, 6'b100011, 1'b0, 4'd3, C_MEMRD_ERR);
        step("after_memrd_abort", 1'b0, 6'b100011, 1'b1, 4'd0, C_FETCH_RDY);
        step("next_decode", 1'b0, 6'b001000, 1'b1, 4'd1, C_DECODE);

        if (sb_q.size() != 0) begin
            total_cnt++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
